// File: rtl/math_cabs_arb_pkg.sv
// Shared constants and helpers for the channel-multiplexed complex-magnitude block.
// Covers the magnitude pipeline geometry and the per-stage square-root step.
package math_cabs_arb_pkg;

    localparam int CABS_LAT   = 9;
    localparam int CABS_IN_W  = 16;
    localparam int CABS_OUT_W = 17;

    localparam int SQ_W   = 2 * CABS_IN_W;
    localparam int ROOT_W = CABS_IN_W;
    localparam int REM_W  = ROOT_W + 4;

    typedef struct packed {
        logic [SQ_W-1:0]   rad;
        logic [REM_W-1:0]  rem;
        logic [ROOT_W-1:0] root;
    } sqrt_st_t;

    // One digit of the restoring square root: consumes the top two radicand bits.
    function automatic sqrt_st_t sqrt_step(input sqrt_st_t s);
        sqrt_st_t          n;
        logic [REM_W-1:0]  trial;
        n.rem = {s.rem[REM_W-3:0], s.rad[SQ_W-1 -: 2]};
        n.rad = {s.rad[SQ_W-3:0], 2'b00};
        trial = {2'b00, s.root, 2'b01};
        if (n.rem >= trial) begin
            n.rem  = n.rem - trial;
            n.root = {s.root[ROOT_W-2:0], 1'b1};
        end else begin
            n.root = {s.root[ROOT_W-2:0], 1'b0};
        end
        return n;
    endfunction

endpackage

// File: rtl/math_cabs_16.sv
// Pipelined |re + j*im| for signed 16-bit inputs: floor(sqrt(re^2 + im^2)).
// One stage forms the sum of squares, eight stages resolve two root bits each.
module math_cabs_16
    import math_cabs_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic signed [CABS_IN_W-1:0] din_re,
    input  logic signed [CABS_IN_W-1:0] din_im,
    output logic [CABS_OUT_W-1:0]       dout
);

    logic signed [SQ_W-1:0] sq_re;
    logic signed [SQ_W-1:0] sq_im;
    logic [SQ_W-1:0]        sum_sq;
    sqrt_st_t               st [CABS_LAT];

    always_comb begin
        sq_re  = din_re * din_re;
        sq_im  = din_im * din_im;
        sum_sq = $unsigned(sq_re) + $unsigned(sq_im);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CABS_LAT; i++) begin
                st[i] <= '0;
            end
        end else if (ena) begin
            st[0] <= '{rad: sum_sq, rem: '0, root: '0};
            for (int unsigned i = 1; i < CABS_LAT; i++) begin
                st[i] <= sqrt_step(sqrt_step(st[i-1]));
            end
        end
    end

    assign dout = {1'b0, st[CABS_LAT-1].root};

endmodule

// File: rtl/math_rr_arb.sv
// Round-robin arbiter: one-hot grant from the first request at or after the pointer.
// The pointer moves past the winner only on cycles the grant is actually taken (adv).
module math_rr_arb #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  idx
);

    logic [CW-1:0] ptr;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            int unsigned k;
            k = (int'(ptr) + i) % NCH;
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                idx      = CW'(k);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv && found) begin
            if (int'(idx) == NCH - 1) begin
                ptr <= '0;
            end else begin
                ptr <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/math_cabs_arb.sv
// Shares one magnitude pipeline among NCH channels with round-robin grants.
// Channel tags ride a shift register alongside the datapath; backpressure freezes both.
module math_cabs_arb
    import math_cabs_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int LAT = CABS_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           chan_en,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    input  logic [CABS_IN_W*NCH-1:0] in_re,
    input  logic [CABS_IN_W*NCH-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CABS_OUT_W-1:0]    out_abs,
    output logic [CW-1:0]            out_chan,
    output logic [3:0]               inflight
);

    logic [NCH-1:0]       req;
    logic [NCH-1:0]       grant;
    logic [CW-1:0]        idx;
    logic                 adv;
    logic                 accept;
    logic                 out_xfer;
    logic                 cabs_rst;
    logic [CABS_IN_W-1:0] re_mux;
    logic [CABS_IN_W-1:0] im_mux;
    logic [LAT-1:0]       vld;
    logic [CW-1:0]        chan [LAT];

    always_comb begin
        req      = in_valid & chan_en;
        adv      = !(vld[LAT-1] && !out_ready);
        in_ready = grant & {NCH{adv}};
        accept   = adv && (|grant);
        out_xfer = vld[LAT-1] && out_ready;
        cabs_rst = ~rst;
    end

    math_rr_arb #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .adv   (adv),
        .grant (grant),
        .idx   (idx)
    );

    // Zero inputs on idle cycles keep the datapath deterministic for bubbles.
    always_comb begin
        re_mux = '0;
        im_mux = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                re_mux = in_re[CABS_IN_W*i +: CABS_IN_W];
                im_mux = in_im[CABS_IN_W*i +: CABS_IN_W];
            end
        end
    end

    math_cabs_16 u_cabs (
        .clk    (clk),
        .rst    (cabs_rst),
        .ena    (adv),
        .din_re (re_mux),
        .din_im (im_mux),
        .dout   (out_abs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                chan[i] <= '0;
            end
        end else if (adv) begin
            vld     <= {vld[LAT-2:0], |grant};
            chan[0] <= idx;
            for (int unsigned i = 1; i < LAT; i++) begin
                chan[i] <= chan[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({accept, out_xfer})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_comb begin
        out_valid = vld[LAT-1];
        out_chan  = chan[LAT-1];
    end

endmodule

// File: tb/tb_math_cabs_arb.sv
// Bench for math_cabs_arb: reference arbitration/latency model feeds a scoreboard,
// an independent monitor pops expected results whenever an output transfers.
module tb_math_cabs_arb;
    import math_cabs_arb_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int LAT = CABS_LAT;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NCH-1:0]           chan_en = '1;
    logic [NCH-1:0]           in_valid = '0;
    logic [NCH-1:0]           in_ready;
    logic [CABS_IN_W*NCH-1:0] in_re = '0;
    logic [CABS_IN_W*NCH-1:0] in_im = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [CABS_OUT_W-1:0]    out_abs;
    logic [CW-1:0]            out_chan;
    logic [3:0]               inflight;

    math_cabs_arb #(.NCH(NCH), .CW(CW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .chan_en   (chan_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_abs   (out_abs),
        .out_chan  (out_chan),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int abs_v; } exp_t;
    exp_t sb[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned ch2_grants = 0;

    // Reference state: pending results with their pipeline position, pointer, count.
    bit m_v  [LAT];
    int m_ch [LAT];
    int m_ptr  = 0;
    int m_infl = 0;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int gold_abs(input int re, input int im);
        longint s;
        longint r;
        s = longint'(re) * re + longint'(im) * im;
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LAT; i++) begin
            m_v[i]  = 1'b0;
            m_ch[i] = 0;
        end
        m_ptr  = 0;
        m_infl = 0;
        sb.delete();
    endtask

    // Reference model: arbitration, readiness, output presence and occupancy.
    always @(negedge clk) begin
        if (rst) begin
            logic [NCH-1:0] req;
            logic [NCH-1:0] exp_rdy;
            int             g;
            bit             adv;
            req = in_valid & chan_en;
            adv = !(m_v[LAT-1] && !out_ready);
            g = -1;
            for (int i = 0; i < NCH; i++) begin
                int k;
                k = (m_ptr + i) % NCH;
                if (g < 0 && req[k]) g = k;
            end
            exp_rdy = (g >= 0 && adv) ? (NCH'(1) << g) : '0;
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, m_v[LAT-1]);
            if (m_v[LAT-1]) check("out_chan_model", out_chan, m_ch[LAT-1]);
            check("inflight", inflight, m_infl);
            if (in_ready[2]) ch2_grants++;
            if (adv) begin
                if (m_v[LAT-1]) m_infl--;
                for (int i = LAT - 1; i > 0; i--) begin
                    m_v[i]  = m_v[i-1];
                    m_ch[i] = m_ch[i-1];
                end
                m_v[0]  = (g >= 0);
                m_ch[0] = (g >= 0) ? g : 0;
                if (g >= 0) begin
                    exp_t e;
                    e.ch    = g;
                    e.abs_v = gold_abs(int'($signed(in_re[16*g +: 16])),
                                       int'($signed(in_im[16*g +: 16])));
                    sb.push_back(e);
                    m_infl++;
                    m_ptr = (g + 1) % NCH;
                end
            end
        end
    end

    // Monitor: result data/channel on every output transfer, stability under stall.
    logic [CABS_OUT_W-1:0] prev_abs;
    logic [CW-1:0]         prev_chan;
    bit                    prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_abs", out_abs, prev_abs);
                check("hold_chan", out_chan, prev_chan);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: actual output chan %0d abs %0d required none at %0t",
                             out_chan, out_abs, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_abs", out_abs, e.abs_v);
                    check("out_chan", out_chan, e.ch);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_abs   = out_abs;
            prev_chan  = out_chan;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NCH; i++) begin
            in_re[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            in_im[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'h7fff : 16'($urandom);
        end
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (LAT + 4) step();
    endtask

    initial begin
        int k;
        model_reset();
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_inflight", inflight, 0);
        step();
        #2 rst = 1'b1;
        step();

        // Single channel, known magnitude and exact latency
        in_re[16*1 +: 16] = 16'sd3;
        in_im[16*1 +: 16] = 16'sd4;
        in_valid = 4'b0010;
        @(negedge clk);
        check("t1_ready", in_ready, 4'b0010);
        step();
        in_valid = '0;
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("t1_latency", k, 9);
        check("t1_abs", out_abs, 5);
        check("t1_chan", out_chan, 1);
        drain();

        // All channels continuously valid
        in_valid = '1;
        repeat (40) begin
            rand_data();
            step();
        end
        drain();

        // Stall while results are pending
        in_valid = '1;
        repeat (12) begin
            rand_data();
            step();
        end
        out_ready = 1'b0;
        repeat (4) begin
            rand_data();
            step();
        end
        @(negedge clk);
        check("t3_stall_inflight", inflight, 9);
        check("t3_stall_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        repeat (10) begin
            rand_data();
            step();
        end
        drain();

        // Sparse single channel against a blocked output
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rand_data();
            in_valid = (c % 2 == 0) ? 4'b0100 : 4'b0000;
            step();
        end
        @(negedge clk);
        check("t4_inflight", inflight, 5);
        check("t4_out_valid", out_valid, 1);
        step();
        drain();

        // Masked channel is never granted
        chan_en    = 4'b1011;
        ch2_grants = 0;
        in_valid   = '1;
        repeat (30) begin
            rand_data();
            step();
        end
        check("t5_ch2_grants", ch2_grants, 0);
        chan_en = '1;
        drain();

        // Random traffic, masks and backpressure
        repeat (300) begin
            rand_data();
            in_valid  = NCH'($urandom);
            chan_en   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chan_en = '1;
        drain();
        check("drain_sb_empty", sb.size(), 0);

        // Reset mid-stream with seven samples in flight
        in_valid = '1;
        repeat (7) begin
            rand_data();
            step();
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_inflight", inflight, 0);
        step();
        step();
        #2 rst = 1'b1;
        @(negedge clk);
        check("t6_first_grant", in_ready, 4'b0001);
        repeat (20) begin
            rand_data();
            step();
        end
        drain();
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
